// File: rtl/rdma_xmit.sv
// rtl/rdma_xmit.sv - AXI4 write-burst slave that emits one RDMA-over-UDP packet per burst
// Header beat (Eth+IPv4+UDP+RDMA) followed by the burst data passed straight through.
module rdma_xmit #(
   parameter int          DATA_WBITS = 512,
   parameter int          ADDR_WBITS = 64,
   parameter logic [47:0] SRC_MAC    = 48'h0,
   parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
   parameter logic [31:0] SRC_IP     = 32'h0,
   parameter logic [31:0] DST_IP     = 32'h0,
   parameter logic [15:0] SRC_PORT   = 16'd32002,
   parameter logic [15:0] DST_PORT   = 16'd32002
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [ADDR_WBITS-1:0]   S_AXI_AWADDR,
   input  logic [7:0]              S_AXI_AWLEN,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   input  logic [DATA_WBITS-1:0]   S_AXI_WDATA,
   input  logic [DATA_WBITS/8-1:0] S_AXI_WSTRB,
   input  logic                    S_AXI_WLAST,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   output logic [1:0]              S_AXI_BRESP,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   output logic [DATA_WBITS-1:0]   AXIS_RDMA_TDATA,
   output logic [DATA_WBITS/8-1:0] AXIS_RDMA_TKEEP,
   output logic                    AXIS_RDMA_TLAST,
   output logic                    AXIS_RDMA_TVALID,
   input  logic                    AXIS_RDMA_TREADY
);

   typedef enum logic [1:0] {IDLE, HDR, DATA, RESP} state_t;

   state_t                  state, state_nx;
   logic                    live;
   logic [ADDR_WBITS-1:0]   addr_q;
   logic [7:0]              len_q;
   logic [7:0]              beat_cnt;
   logic                    err;
   logic [15:0]             csum_q;
   logic                    aw_hs;
   logic                    w_hs;
   logic                    last_beat;
   logic [15:0]             udp_len;
   logic [15:0]             ip_len;
   logic [511:0]            hdr_be;
   logic [511:0]            hdr_le;

   function automatic logic [15:0] udp_len_of(input logic [7:0] len);
      return (({8'd0, len} + 16'd1) << 6) + 16'd30;
   endfunction

   function automatic logic [15:0] ip_csum_of(input logic [15:0] ipl);
      logic [19:0] sum;
      sum = 20'h04500 + {4'd0, ipl} + 20'h04000 + 20'h04011
          + {4'd0, SRC_IP[31:16]} + {4'd0, SRC_IP[15:0]}
          + {4'd0, DST_IP[31:16]} + {4'd0, DST_IP[15:0]};
      sum = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
      sum = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
      return ~sum[15:0];
   endfunction

   assign aw_hs     = (state == IDLE) && live && S_AXI_AWVALID;
   assign w_hs      = (state == DATA) && S_AXI_WVALID && AXIS_RDMA_TREADY;
   assign last_beat = (beat_cnt == len_q);
   assign udp_len   = udp_len_of(len_q);
   assign ip_len    = udp_len + 16'd20;

   assign hdr_be = {DST_MAC, SRC_MAC, 16'h0800,
                    16'h4500, ip_len, 16'h0000, 16'h4000, 16'h4011, csum_q, SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, udp_len, 16'h0000,
                    64'(addr_q), len_q, 104'h0};

   // First header byte goes on the lowest lane of the bus.
   always_comb begin
      hdr_le = '0;
      for (int i = 0; i < 64; i++) hdr_le[8*i +: 8] = hdr_be[8*(63-i) +: 8];
   end

   // live holds AWREADY low while reset is asserted and for the first edge after it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         live     <= 1'b0;
         addr_q   <= '0;
         len_q    <= '0;
         beat_cnt <= '0;
         err      <= 1'b0;
         csum_q   <= '0;
      end else begin
         state <= state_nx;
         live  <= 1'b1;
         if (aw_hs) begin
            addr_q   <= S_AXI_AWADDR;
            len_q    <= S_AXI_AWLEN;
            beat_cnt <= '0;
            err      <= 1'b0;
            csum_q   <= ip_csum_of(udp_len_of(S_AXI_AWLEN) + 16'd20);
         end
         if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (S_AXI_WLAST != last_beat) err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nx         = state;
      S_AXI_AWREADY    = 1'b0;
      S_AXI_WREADY     = 1'b0;
      S_AXI_BVALID     = 1'b0;
      S_AXI_BRESP      = 2'b00;
      AXIS_RDMA_TDATA  = '0;
      AXIS_RDMA_TKEEP  = '0;
      AXIS_RDMA_TLAST  = 1'b0;
      AXIS_RDMA_TVALID = 1'b0;
      case (state)
         IDLE: begin
            S_AXI_AWREADY = live;
            if (aw_hs) state_nx = HDR;
         end
         HDR: begin
            AXIS_RDMA_TVALID = 1'b1;
            AXIS_RDMA_TKEEP  = '1;
            AXIS_RDMA_TDATA  = hdr_le;
            if (AXIS_RDMA_TREADY) state_nx = DATA;
         end
         DATA: begin
            AXIS_RDMA_TDATA  = S_AXI_WDATA;
            AXIS_RDMA_TKEEP  = S_AXI_WSTRB;
            AXIS_RDMA_TVALID = S_AXI_WVALID;
            AXIS_RDMA_TLAST  = last_beat;
            S_AXI_WREADY     = AXIS_RDMA_TREADY;
            if (w_hs && last_beat) state_nx = RESP;
         end
         RESP: begin
            S_AXI_BVALID = 1'b1;
            S_AXI_BRESP  = err ? 2'b10 : 2'b00;
            if (S_AXI_BREADY) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rdma_xmit.sv
// tb/tb_rdma_xmit.sv - directed self-checking bench for rdma_xmit
module tb_rdma_xmit;

   localparam logic [47:0] T_SRC_MAC  = 48'h0200_0000_0001;
   localparam logic [47:0] T_DST_MAC  = 48'hFFFF_FFFF_FFFF;
   localparam logic [31:0] T_SRC_IP   = 32'h0A00_0001;
   localparam logic [31:0] T_DST_IP   = 32'h0A00_0002;
   localparam logic [15:0] T_SRC_PORT = 16'd32002;
   localparam logic [15:0] T_DST_PORT = 16'd32002;

   logic         clk;
   logic         resetn;
   logic [63:0]  S_AXI_AWADDR;
   logic [7:0]   S_AXI_AWLEN;
   logic         S_AXI_AWVALID;
   logic         S_AXI_AWREADY;
   logic [511:0] S_AXI_WDATA;
   logic [63:0]  S_AXI_WSTRB;
   logic         S_AXI_WLAST;
   logic         S_AXI_WVALID;
   logic         S_AXI_WREADY;
   logic [1:0]   S_AXI_BRESP;
   logic         S_AXI_BVALID;
   logic         S_AXI_BREADY;
   logic [511:0] AXIS_RDMA_TDATA;
   logic [63:0]  AXIS_RDMA_TKEEP;
   logic         AXIS_RDMA_TLAST;
   logic         AXIS_RDMA_TVALID;
   logic         AXIS_RDMA_TREADY;

   rdma_xmit #(
      .DATA_WBITS(512), .ADDR_WBITS(64),
      .SRC_MAC(T_SRC_MAC), .DST_MAC(T_DST_MAC),
      .SRC_IP(T_SRC_IP), .DST_IP(T_DST_IP),
      .SRC_PORT(T_SRC_PORT), .DST_PORT(T_DST_PORT)
   ) dut (
      .clk(clk), .resetn(resetn),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .AXIS_RDMA_TDATA(AXIS_RDMA_TDATA), .AXIS_RDMA_TKEEP(AXIS_RDMA_TKEEP),
      .AXIS_RDMA_TLAST(AXIS_RDMA_TLAST), .AXIS_RDMA_TVALID(AXIS_RDMA_TVALID),
      .AXIS_RDMA_TREADY(AXIS_RDMA_TREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit tready_rand = 1'b0;
   logic [576:0] got_q[$];
   logic [576:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [576:0] got, input logic [576:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] be_field(input logic [576:0] b, input int k, input int nb);
      logic [63:0] r;
      r = '0;
      for (int j = 0; j < nb; j++) r = (r << 8) | 64'(b[8*(k+j) +: 8]);
      return r;
   endfunction

   function automatic logic [511:0] model_hdr(input logic [63:0] addr, input logic [7:0] len);
      logic [63:0]  fv[17];
      int           fn[17];
      logic [7:0]   bytes[64];
      logic [15:0]  w[10];
      int unsigned  s, ipl, udp;
      int           k;
      logic [511:0] r;
      udp = (int'(len) + 1) * 64 + 30;
      ipl = udp + 20;
      w = '{16'h4500, 16'(ipl), 16'h0000, 16'h4000, 16'h4011, 16'h0000,
            T_SRC_IP[31:16], T_SRC_IP[15:0], T_DST_IP[31:16], T_DST_IP[15:0]};
      s = 0;
      foreach (w[i]) s += 32'(w[i]);
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      fv = '{64'(T_DST_MAC), 64'(T_SRC_MAC), 64'h0800, 64'h4500, 64'(ipl), 64'h0,
             64'h4000, 64'h4011, 64'(~s & 32'hFFFF), 64'(T_SRC_IP), 64'(T_DST_IP),
             64'(T_SRC_PORT), 64'(T_DST_PORT), 64'(udp), 64'h0, addr, 64'(len)};
      fn = '{6, 6, 2, 2, 2, 2, 2, 2, 2, 4, 4, 2, 2, 2, 2, 8, 1};
      foreach (bytes[i]) bytes[i] = 8'h00;
      k = 0;
      for (int f = 0; f < 17; f++)
         for (int j = fn[f] - 1; j >= 0; j--) begin
            bytes[k] = fv[f][8*j +: 8];
            k++;
         end
      for (int i = 0; i < 64; i++) r[8*i +: 8] = bytes[i];
      return r;
   endfunction

   initial forever begin
      @(posedge clk);
      #1;
      AXIS_RDMA_TREADY = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Stream monitor; a stalled beat must already equal the next expected beat.
   initial forever begin
      @(negedge clk);
      if (resetn) begin
         if (AXIS_RDMA_TVALID && !AXIS_RDMA_TREADY && got_q.size() < exp_q.size())
            check_eq("stall_beat", {AXIS_RDMA_TLAST, AXIS_RDMA_TKEEP, AXIS_RDMA_TDATA}, exp_q[got_q.size()]);
         if (AXIS_RDMA_TVALID && AXIS_RDMA_TREADY)
            got_q.push_back({AXIS_RDMA_TLAST, AXIS_RDMA_TKEEP, AXIS_RDMA_TDATA});
      end
   end

   task automatic do_burst(input logic [63:0] addr, input logic [7:0] len, input bit gaps,
                           input int extra_last, input logic [1:0] exp_resp);
      int           n;
      int unsigned  g;
      logic [511:0] d;
      logic [63:0]  s;
      got_q.delete();
      exp_q.delete();
      exp_q.push_back({1'b0, {64{1'b1}}, model_hdr(addr, len)});
      for (int i = 0; i <= int'(len); i++) begin
         for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom;
         s = {$urandom, $urandom};
         exp_q.push_back({1'(i == int'(len)), s, d});
      end
      @(posedge clk); #1;
      S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!S_AXI_AWREADY && n < 50);
      check_eq("aw_ready", 577'(S_AXI_AWREADY), 577'(1));
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0;
      @(negedge clk);
      check_eq("hdr_valid_next", 577'(AXIS_RDMA_TVALID), 577'(1));
      for (int i = 0; i <= int'(len); i++) begin
         @(posedge clk); #1;
         if (gaps) begin
            g = $urandom_range(0, 2);
            if (g > 0) begin
               S_AXI_WVALID = 1'b0;
               repeat (g) @(posedge clk);
               #1;
            end
         end
         S_AXI_WDATA  = exp_q[i+1][511:0];
         S_AXI_WSTRB  = exp_q[i+1][575:512];
         S_AXI_WLAST  = (i == int'(len)) || (i == extra_last);
         S_AXI_WVALID = 1'b1;
         n = 0;
         do begin @(negedge clk); n++; end while (!S_AXI_WREADY && n < 200);
         check_eq($sformatf("w_ready%0d", i), 577'(S_AXI_WREADY), 577'(1));
      end
      @(posedge clk); #1;
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_BREADY = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!S_AXI_BVALID && n < 50);
      check_eq("bvalid", 577'(S_AXI_BVALID), 577'(1));
      check_eq("bresp", 577'(S_AXI_BRESP), 577'(exp_resp));
      @(posedge clk); #1;
      S_AXI_BREADY = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("beat_count", 577'(got_q.size()), 577'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) check_eq($sformatf("beat%0d", i), got_q[i], exp_q[i]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      resetn = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0; AXIS_RDMA_TREADY = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_outputs", 577'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                                    AXIS_RDMA_TVALID, AXIS_RDMA_TLAST}), 577'(0));
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_awready", 577'(S_AXI_AWREADY), 577'(1));

      do_burst(64'h1000, 8'd0, 1'b0, -1, 2'b00);
      if (got_q.size() > 0) begin
         check_eq("t1_udp_len", 577'(be_field(got_q[0], 38, 2)), 577'(16'h005E));
         check_eq("t1_ip_len", 577'(be_field(got_q[0], 16, 2)), 577'(16'h0072));
         check_eq("t1_target", 577'(be_field(got_q[0], 42, 8)), 577'(64'h1000));
         check_eq("t1_burst_len", 577'(be_field(got_q[0], 50, 1)), 577'(8'h00));
         check_eq("t1_ip_csum", 577'(be_field(got_q[0], 24, 2)), 577'(16'h2679));
      end

      do_burst(64'hDEAD_BEEF_0000_0040, 8'd255, 1'b0, -1, 2'b00);
      if (got_q.size() > 0) begin
         check_eq("t2_udp_len", 577'(be_field(got_q[0], 38, 2)), 577'(16'h401E));
         check_eq("t2_ip_len", 577'(be_field(got_q[0], 16, 2)), 577'(16'h4032));
      end

      tready_rand = 1'b1;
      do_burst(64'h0000_0000_0002_0005, 8'd7, 1'b1, -1, 2'b00);
      tready_rand = 1'b0;

      do_burst(64'h3000, 8'd3, 1'b0, 1, 2'b10);

      got_q.delete();
      exp_q.delete();
      @(posedge clk); #1;
      S_AXI_AWADDR = 64'h5000; S_AXI_AWLEN = 8'd7; S_AXI_AWVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!S_AXI_AWREADY && n < 50);
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         S_AXI_WDATA = {16{$urandom}}; S_AXI_WSTRB = '1; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
         if (i < 2) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!S_AXI_WREADY && n < 50);
         end
      end
      #1;
      check_eq("t5_mid_valid", 577'(AXIS_RDMA_TVALID), 577'(1));
      resetn = 1'b0;
      #1;
      check_eq("t5_rst_outputs", 577'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                                       AXIS_RDMA_TVALID, AXIS_RDMA_TLAST}), 577'(0));
      @(negedge clk);
      S_AXI_WVALID = 1'b0;
      resetn = 1'b1;
      do_burst(64'h6000, 8'd0, 1'b0, -1, 2'b00);

      do_burst(64'h7000, 8'd0, 1'b0, -1, 2'b00);
      if (got_q.size() > 0)
         check_eq("t6_ip_csum", 577'(be_field(got_q[0], 24, 2)), 577'(16'h2679));
      do_burst(64'h7040, 8'd0, 1'b0, -1, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
